// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the message sources, the arbiter and the UART serializer.
// The arbiter uses the slave view; the requester/serializer side uses the master view.
interface uart_tx_arbiter_if #(
  parameter int unsigned REQ_NUM = 2
);
  logic [REQ_NUM-1:0]   reqValid;
  logic [8*REQ_NUM-1:0] reqData;
  logic [REQ_NUM-1:0]   reqLast;
  logic [REQ_NUM-1:0]   reqReady;
  logic [7:0]           txData;
  logic                 txValid;
  logic                 txReady;
  logic [REQ_NUM-1:0]   grant;
  logic                 busy;
  logic                 abortPulse;

  modport slave (
    input  reqValid, reqData, reqLast, txReady,
    output reqReady, txData, txValid, grant, busy, abortPulse
  );

  modport master (
    output reqValid, reqData, reqLast, txReady,
    input  reqReady, txData, txValid, grant, busy, abortPulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one byte UART transmitter between
// REQ_NUM sources, with a stall watchdog that reclaims the line from a silent owner.
module uart_tx_arbiter #(
  parameter int unsigned REQ_NUM     = 2,
  parameter int unsigned STALL_LIMIT = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             uartTxRstN,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;

  logic               ownValid, ownLast, xfer, stalled, stallHit, found;
  logic [IDX_W-1:0]   nextPtr;
  int unsigned        cand;

  always_ff @(posedge clk or negedge uartTxRstN) begin
    if (!uartTxRstN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rrPtr_q    <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rrPtr_q    <= rrPtr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // Only a silent owner counts as stalled; backpressure leaves txValid high.
  always_comb begin
    ownValid = bus.reqValid[owner_q];
    ownLast  = bus.reqLast[owner_q];
    xfer     = (state_q == GRANT) && ownValid && bus.txReady;
    stalled  = (state_q == GRANT) && !ownValid;
    stallHit = stalled && (stallCnt_q == CNT_W'(STALL_LIMIT - 1));
    nextPtr  = (owner_q == IDX_W'(REQ_NUM - 1)) ? '0 : owner_q + IDX_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rrPtr_d    = rrPtr_q;
    stallCnt_d = stallCnt_q;
    found      = 1'b0;
    cand       = 0;
    case (state_q)
      IDLE: begin
        stallCnt_d = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
          if (!found && bus.reqValid[IDX_W'((32'(rrPtr_q) + k) % REQ_NUM)]) begin
            found = 1'b1;
            cand  = (32'(rrPtr_q) + k) % REQ_NUM;
          end
        end
        if (found) begin
          state_d = GRANT;
          owner_d = IDX_W'(cand);
          grant_d = REQ_NUM'(1) << cand;
        end
      end
      GRANT: begin
        if (xfer) begin
          stallCnt_d = '0;
          if (ownLast) begin
            state_d = IDLE;
            grant_d = '0;
            rrPtr_d = nextPtr;
          end
        end else if (stallHit) begin
          state_d    = IDLE;
          grant_d    = '0;
          rrPtr_d    = nextPtr;
          stallCnt_d = '0;
        end else if (stalled) begin
          stallCnt_d = stallCnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == GRANT);
    bus.grant      = grant_q;
    bus.txValid    = (state_q == GRANT) && ownValid;
    bus.txData     = bus.reqData[{owner_q, 3'b000} +: 8];
    bus.reqReady   = (state_q == GRANT) ? (grant_q & {REQ_NUM{bus.txReady}}) : '0;
    bus.abortPulse = stallHit;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: sources feed from per-requester byte
// queues, expected (grant, byte) pairs are queued at stimulus time.
module tb_uart_tx_arbiter;
  localparam int unsigned N   = 2;
  localparam int unsigned LIM = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.REQ_NUM(N)) bus ();

  uart_tx_arbiter #(
    .REQ_NUM    (N),
    .STALL_LIMIT(LIM),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .uartTxRstN(rst_n),
    .bus       (bus.slave)
  );

  logic [8:0]  srcQ0[$];
  logic [8:0]  srcQ1[$];
  logic [9:0]  expQ[$];
  int unsigned nChecks = 0;
  int unsigned nPass   = 0;
  int unsigned xfers   = 0;
  int unsigned aborts  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int unsigned src, input logic [7:0] d, input logic last,
                      input logic expectIt);
    if (src == 0) srcQ0.push_back({last, d});
    else          srcQ1.push_back({last, d});
    if (expectIt) expQ.push_back({(src == 0) ? 2'b01 : 2'b10, d});
  endtask

  task automatic wait_xfers(input int unsigned target, input int unsigned budget);
    for (int unsigned n = 0; xfers < target; n++) begin
      if (n >= budget) begin
        check("xfer_timeout", xfers, target);
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_idle(input int unsigned budget);
    for (int unsigned n = 0; expQ.size() != 0 || bus.busy; n++) begin
      if (n >= budget) begin
        check("idle_timeout", expQ.size(), 0);
        break;
      end
      tick(1);
    end
  endtask

  // Sources: present queue heads shortly after each rising edge.
  initial begin
    logic [1:0]  v, l;
    logic [15:0] d;
    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.reqLast  = '0;
    forever begin
      @(posedge clk);
      #1;
      v = '0; l = '0; d = bus.reqData;
      if (srcQ0.size() != 0) begin v[0] = 1'b1; d[7:0]  = srcQ0[0][7:0]; l[0] = srcQ0[0][8]; end
      if (srcQ1.size() != 0) begin v[1] = 1'b1; d[15:8] = srcQ1[0][7:0]; l[1] = srcQ1[0][8]; end
      bus.reqValid = v;
      bus.reqData  = d;
      bus.reqLast  = l;
    end
  end

  // Monitor: mid-cycle values equal what the next rising edge will capture.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [8:0] tmp;
    if (rst_n) begin
      check("ready_nonowner", 32'(bus.reqReady & ~bus.grant), 0);
      if (!bus.busy) check("idle_txvalid", 32'(bus.txValid), 0);
      if (bus.abortPulse) aborts++;
      if (bus.txValid && bus.txReady) begin
        xfers++;
        if (expQ.size() == 0) begin
          check("unexpected_xfer", 32'(bus.txData), 32'h1ff);
        end else begin
          e = expQ.pop_front();
          check("txData", 32'(bus.txData), 32'(e[7:0]));
          check("grant", 32'(bus.grant), 32'(e[9:8]));
        end
      end
      if (bus.reqValid[0] && bus.reqReady[0]) tmp = srcQ0.pop_front();
      if (bus.reqValid[1] && bus.reqReady[1]) tmp = srcQ1.pop_front();
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int unsigned base;
    rst_n       = 1'b0;
    bus.txReady = 1'b0;
    #3;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_txValid", 32'(bus.txValid), 0);
    check("rst_reqReady", 32'(bus.reqReady), 0);
    check("rst_abort", 32'(bus.abortPulse), 0);
    tick(3);
    rst_n       = 1'b1;
    bus.txReady = 1'b1;
    tick(2);

    // Three-byte message from req0; leaves rrPtr at 1
    push(0, 8'h41, 1'b0, 1'b1);
    push(0, 8'h42, 1'b0, 1'b1);
    push(0, 8'h43, 1'b1, 1'b1);
    wait_idle(50);

    // Simultaneous with rrPtr=1: req1 first, then req0
    push(1, 8'hB0, 1'b1, 1'b1);
    push(0, 8'hA0, 1'b0, 1'b1);
    push(0, 8'hA1, 1'b1, 1'b1);
    wait_idle(50);

    // One-byte message with cycle-exact latency; leaves rrPtr at 0
    base = xfers;
    push(1, 8'h0A, 1'b1, 1'b1);
    tick(1);
    check("t6_busy_pre", 32'(bus.busy), 0);
    tick(1);
    check("t6_busy", 32'(bus.busy), 1);
    check("t6_txValid", 32'(bus.txValid), 1);
    check("t6_txData", 32'(bus.txData), 32'h0A);
    tick(1);
    check("t6_busy_post", 32'(bus.busy), 0);
    tick(3);
    check("t6_count", xfers - base, 1);

    // Simultaneous with rrPtr=0: req0 first, then req1
    push(0, 8'hC0, 1'b1, 1'b1);
    push(1, 8'hD0, 1'b0, 1'b1);
    push(1, 8'hD1, 1'b1, 1'b1);
    wait_idle(50);

    // Backpressure for 50 cycles mid-message
    base = xfers;
    push(0, 8'h10, 1'b0, 1'b1);
    push(0, 8'h11, 1'b0, 1'b1);
    push(0, 8'h12, 1'b0, 1'b1);
    push(0, 8'h13, 1'b1, 1'b1);
    wait_xfers(base + 1, 50);
    bus.txReady = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("bp_txData", 32'(bus.txData), 32'h11);
      check("bp_txValid", 32'(bus.txValid), 1);
      check("bp_abort", 32'(bus.abortPulse), 0);
    end
    bus.txReady = 1'b1;
    wait_idle(50);
    check("bp_aborts", aborts, 0);

    // Watchdog: req1 goes silent after one byte, req0 waiting
    base = xfers;
    push(1, 8'h77, 1'b0, 1'b1);
    wait_xfers(base + 1, 50);
    push(0, 8'h55, 1'b1, 1'b1);
    for (int j = 0; j < 8; j++) begin
      check("wd_busy", 32'(bus.busy), 1);
      check("wd_abort", 32'(bus.abortPulse), (j == 7) ? 1 : 0);
      tick(1);
    end
    check("wd_busy_after", 32'(bus.busy), 0);
    tick(1);
    check("wd_regrant", 32'(bus.grant), 32'h1);
    wait_idle(50);
    check("wd_aborts", aborts, 1);
    check("wd_req1_left", srcQ1.size(), 0);

    // Asynchronous reset after the 2nd of 4 bytes; rrPtr was 1 beforehand
    base = xfers;
    push(0, 8'h21, 1'b0, 1'b1);
    push(0, 8'h22, 1'b0, 1'b1);
    push(0, 8'h23, 1'b0, 1'b0);
    push(0, 8'h24, 1'b1, 1'b0);
    wait_xfers(base + 2, 50);
    check("rst_mid_valid", 32'(bus.txValid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txValid", 32'(bus.txValid), 0);
    check("rst_mid_grant", 32'(bus.grant), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_reqReady", 32'(bus.reqReady), 0);
    check("rst_mid_pending", expQ.size(), 0);
    srcQ0.delete();
    srcQ1.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    push(0, 8'h31, 1'b1, 1'b1);
    push(1, 8'h32, 1'b1, 1'b1);
    wait_idle(50);

    check("final_aborts", aborts, 1);
    check("final_expQ", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
